// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side handshake and result bus of the shared ALU arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic req0, req1;
  logic [1:0] op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] result;
  logic z, n, busy;
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, result, z, n, busy
  );
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, result, z, n, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_add,
  output logic             alu_inc,
  output logic             alu_neg,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n
);
  localparam logic [3:0] SETTLE = SETTLE_CYCLES < 1 ? 4'd1 : 4'(SETTLE_CYCLES);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic sel, pri, win, any;
  logic [1:0] op;
  logic [3:0] cnt;
  assign any = bus.req0 | bus.req1;
  // pri names the favoured port; it only matters when both request
  assign win = (bus.req0 & bus.req1) ? pri : bus.req1;
  assign bus.busy = state != IDLE;
  assign alu_add = state == EXEC && op == 2'd0;
  assign alu_inc = state == EXEC && op == 2'd1;
  assign alu_neg = state == EXEC && op == 2'd2;
  assign alu_sub = state == EXEC && op == 2'd3;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (any ? EXEC : IDLE) :
               state == EXEC ? (cnt <= 4'd1 ? DONE : EXEC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      pri <= 1'b0;
      op <= 2'd0;
      cnt <= 4'd0;
      alu_a <= '0;
      alu_b <= '0;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.result <= '0;
      bus.z <= 1'b0;
      bus.n <= 1'b0;
    end else begin
      state <= state_nx;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      if (state == IDLE && any) begin
        sel <= win;
        op <= win ? bus.op1 : bus.op0;
        alu_a <= win ? bus.a1 : bus.a0;
        alu_b <= win ? bus.b1 : bus.b0;
        bus.gnt0 <= ~win;
        bus.gnt1 <= win;
        cnt <= SETTLE;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt <= 4'd1) begin
          bus.result <= alu_out;
          bus.z <= alu_z;
          bus.n <= alu_n;
          bus.done0 <= ~sel;
          bus.done1 <= sel;
        end
      end
      if (state == DONE) pri <= ~sel;
    end
  end
endmodule
